// File: rtl/targ_pred_arbiter.sv
// -----------------------------------------------------------------------------
// targ_pred_arbiter
//
// Arbitrates a single-ported jalr target-predictor table between the
// speculative pipes (lookup reads) and the non-speculative feedback path
// (writes). Each cycle grants at most one operation:
//   - one feedback write, or
//   - one read, picked round-robin among eligible s-pipes.
// Under contention, writes and reads alternate so that neither side starves.
// In-flight reads are tracked through a pred_lat-deep tag pipeline. Each
// returned prediction is steered to the pipe that issued the read. A per-pipe
// flush cancels that pipe's in-flight responses.
//
// Parameters:
//   s_pipe_cnt  number of speculative pipes (2..8)
//   pred_lat    table read latency in cycles (1..4)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              grant enable; in-flight reads drain regardless
//   flush           per-pipe flush
//   req_valid/pc    per-pipe lookup request (req_pc packed, pipe i at [32i+:32])
//   req_ack         one-hot read grant (combinational)
//   rsp_valid/hit/pred_pc  routed table response
//   fb_valid/base_pc/targ_pc, fb_ack  feedback write request / grant
//   tbl_rd_*        table read port
//   tbl_wr_*        table write port
//
// Optional feature (macro TARG_PRED_ARB_STATS_EN):
//   adds saturating counters stat_rd_grant_cnt and stat_rd_stall_cnt.
// -----------------------------------------------------------------------------
module targ_pred_arbiter #(
    parameter int s_pipe_cnt = 3,
    parameter int pred_lat   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [s_pipe_cnt-1:0]    flush,
    input  logic [s_pipe_cnt-1:0]    req_valid,
    input  logic [s_pipe_cnt*32-1:0] req_pc,
    output logic [s_pipe_cnt-1:0]    req_ack,
    output logic [s_pipe_cnt-1:0]    rsp_valid,
    output logic                     rsp_hit,
    output logic [31:0]              rsp_pred_pc,
    input  logic                     fb_valid,
    input  logic [31:0]              fb_base_pc,
    input  logic [31:0]              fb_targ_pc,
    output logic                     fb_ack,
    output logic                     tbl_rd_en,
    output logic [31:0]              tbl_rd_pc,
    input  logic                     tbl_rd_hit,
    input  logic [31:0]              tbl_rd_data,
    output logic                     tbl_wr_en,
    output logic [31:0]              tbl_wr_pc,
    output logic [31:0]              tbl_wr_data
`ifdef TARG_PRED_ARB_STATS_EN
    ,
    output logic [31:0]              stat_rd_grant_cnt,
    output logic [31:0]              stat_rd_stall_cnt
`endif
);

    localparam int id_w = (s_pipe_cnt > 1) ? $clog2(s_pipe_cnt) : 1;

    // Arbitration state
    logic [id_w-1:0]       rr_ptr_r;
    logic                  last_was_wr_r;

    // Tag pipeline: stage k holds a read issued k+1 cycles ago
    logic [pred_lat-1:0]   tag_vld_r;
    logic [id_w-1:0]       tag_id_r [pred_lat];

    logic [s_pipe_cnt-1:0] elig_s;
    logic                  any_elig_s;
    logic                  wr_win_s;
    logic                  rd_win_s;
    logic [id_w-1:0]       gnt_id_s;
    logic [id_w-1:0]       rr_next_s;
    logic [id_w:0]         idx_v;
    logic                  last_vld_s;
    logic [id_w-1:0]       last_id_s;

    // Eligible readers; reset and en=0 suppress every new grant
    always_comb begin
        elig_s = {s_pipe_cnt{1'b0}};
        if (rst || !en) begin
            elig_s = {s_pipe_cnt{1'b0}};
        end else begin
            elig_s = req_valid & ~flush;
        end
    end

    assign any_elig_s = |elig_s;

    // Round-robin search from rr_ptr. The loop scans downward so the last
    // overwrite is the smallest offset, which is the highest priority.
    always_comb begin
        gnt_id_s = {id_w{1'b0}};
        idx_v    = {(id_w + 1){1'b0}};
        for (int k = s_pipe_cnt - 1; k >= 0; k--) begin
            idx_v = {1'b0, rr_ptr_r} + (id_w + 1)'(k);
            if (idx_v >= (id_w + 1)'(s_pipe_cnt)) begin
                idx_v = idx_v - (id_w + 1)'(s_pipe_cnt);
            end else begin
                idx_v = idx_v;
            end
            if (elig_s[idx_v]) begin
                gnt_id_s = idx_v[id_w-1:0];
            end else begin
                gnt_id_s = gnt_id_s;
            end
        end
    end

    // Write wins when nothing competes or the previous grant was a read
    assign wr_win_s = !rst && en && fb_valid && (!any_elig_s || !last_was_wr_r);
    assign rd_win_s = any_elig_s && !wr_win_s;

    // Pointer advance with modulo wrap
    always_comb begin
        rr_next_s = {id_w{1'b0}};
        if (int'(gnt_id_s) == s_pipe_cnt - 1) begin
            rr_next_s = {id_w{1'b0}};
        end else begin
            rr_next_s = gnt_id_s + {{(id_w - 1){1'b0}}, 1'b1};
        end
    end

    // Table port drive and grant acknowledges
    always_comb begin
        req_ack     = {s_pipe_cnt{1'b0}};
        fb_ack      = 1'b0;
        tbl_rd_en   = 1'b0;
        tbl_rd_pc   = 32'h0000_0000;
        tbl_wr_en   = 1'b0;
        tbl_wr_pc   = 32'h0000_0000;
        tbl_wr_data = 32'h0000_0000;
        if (wr_win_s) begin
            fb_ack      = 1'b1;
            tbl_wr_en   = 1'b1;
            tbl_wr_pc   = fb_base_pc;
            tbl_wr_data = fb_targ_pc;
        end else if (rd_win_s) begin
            req_ack[gnt_id_s] = 1'b1;
            tbl_rd_en         = 1'b1;
            tbl_rd_pc         = req_pc[int'(gnt_id_s)*32 +: 32];
        end else begin
            tbl_rd_en = 1'b0;
        end
    end

    // Round-robin pointer and write/read alternation flag; both hold while en=0
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r      <= {id_w{1'b0}};
            last_was_wr_r <= 1'b0;
        end else if (en) begin
            if (wr_win_s) begin
                last_was_wr_r <= 1'b1;
            end else if (rd_win_s) begin
                rr_ptr_r      <= rr_next_s;
                last_was_wr_r <= 1'b0;
            end else begin
                last_was_wr_r <= 1'b0;
            end
        end
    end

    // Tag pipeline shift. Entries of a flushed pipe are dropped as they move.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= {pred_lat{1'b0}};
            for (int k = 0; k < pred_lat; k++) begin
                tag_id_r[k] <= {id_w{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= tbl_rd_en;
            tag_id_r[0]  <= gnt_id_s;
            for (int k = 1; k < pred_lat; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1] && !flush[tag_id_r[k-1]];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    assign last_vld_s = tag_vld_r[pred_lat-1];
    assign last_id_s  = tag_id_r[pred_lat-1];

    // Response routing; a flush in the emerging cycle still suppresses it
    always_comb begin
        rsp_valid   = {s_pipe_cnt{1'b0}};
        rsp_hit     = 1'b0;
        rsp_pred_pc = 32'h0000_0000;
        if (!rst && last_vld_s && !flush[last_id_s]) begin
            rsp_valid[last_id_s] = 1'b1;
            rsp_hit              = tbl_rd_hit;
            rsp_pred_pc          = tbl_rd_data;
        end else begin
            rsp_hit = 1'b0;
        end
    end

`ifdef TARG_PRED_ARB_STATS_EN
    logic rd_stall_s;

    // A stall is any eligible pipe left without a grant this cycle
    assign rd_stall_s = |(elig_s & ~req_ack);

    // Saturating read statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_grant_cnt <= 32'h0000_0000;
            stat_rd_stall_cnt <= 32'h0000_0000;
        end else begin
            if (tbl_rd_en && (stat_rd_grant_cnt != 32'hFFFF_FFFF)) begin
                stat_rd_grant_cnt <= stat_rd_grant_cnt + 32'h0000_0001;
            end
            if (rd_stall_s && (stat_rd_stall_cnt != 32'hFFFF_FFFF)) begin
                stat_rd_stall_cnt <= stat_rd_stall_cnt + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: doc/targ_pred_arbiter.md
Name: targ_pred_arbiter

Overview:
Shares one single-ported jalr target-predictor table between all speculative pipes and the non-speculative feedback path. Each cycle it grants either one table read, chosen round-robin among s-pipe lookup requests, or one feedback write. It tracks in-flight reads through a fixed-latency tag pipeline and routes each returned prediction to the requesting s-pipe. Per-pipe flushes cancel that pipe's pending responses. It sits between the s-pipe manager's target-predictor request/feedback structs and the predictor storage.

Parameters:
s_pipe_cnt, 3, number of speculative pipes (requesters); legal range 2..8
pred_lat, 1, table read latency in cycles from rd_en edge to rd_data valid; legal range 1..4

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
en  input  1  when low, no new grants; in-flight reads still drain
flush  input  s_pipe_cnt  per-pipe flush; cancels in-flight responses for that pipe
req_valid  input  s_pipe_cnt  lookup request per pipe; held until acked
req_pc  input  s_pipe_cnt x 32  lookup base PC per pipe
req_ack  output  s_pipe_cnt  one-hot grant, combinational, same cycle as tbl_rd_en
rsp_valid  output  s_pipe_cnt  one-hot; response for that pipe this cycle
rsp_hit  output  1  table hit flag for the current response
rsp_pred_pc  output  32  predicted target for the current response
fb_valid  input  1  feedback write request; held until acked
fb_base_pc  input  32  feedback jalr PC
fb_targ_pc  input  32  feedback resolved target
fb_ack  output  1  feedback write granted this cycle
tbl_rd_en  output  1  table read strobe
tbl_rd_pc  output  32  table read address PC
tbl_rd_hit  input  1  table hit, valid pred_lat cycles after rd_en
tbl_rd_data  input  32  table data, valid pred_lat cycles after rd_en
tbl_wr_en  output  1  table write strobe
tbl_wr_pc  output  32  table write PC
tbl_wr_data  output  32  table write target

Behaviour:
- Reset (clk edge with rst=1):
  - rr_ptr=0, last_was_wr=0, tag pipeline cleared.
  - All outputs are 0 in the cycle after reset, and while rst is held.
  - Reset mid-operation drops all in-flight reads; no rsp_valid is issued for them.
- Table port usage: at most one of tbl_rd_en or tbl_wr_en is high per cycle. Both are combinational from the current inputs and state.
- Eligible readers: pipe i is eligible iff req_valid[i] && !flush[i] && en.
- Arbitration each cycle, with en=1:
  - If fb_valid and (no eligible reader or last_was_wr=0): write wins. Drive tbl_wr_en=1, tbl_wr_pc=fb_base_pc, tbl_wr_data=fb_targ_pc, fb_ack=1. Set last_was_wr<=1.
  - Else if any reader is eligible: grant the first eligible pipe at or after rr_ptr, with modulo s_pipe_cnt wrap. Drive req_ack[g]=1, tbl_rd_en=1, tbl_rd_pc=req_pc[g]. Set rr_ptr<=(g+1) mod s_pipe_cnt and last_was_wr<=0.
  - Else: idle; last_was_wr<=0.
  - Net effect: writes and reads alternate under contention, so neither side starves. Worst-case read wait is 2*s_pipe_cnt cycles.
- en=0: req_ack=0 and fb_ack=0; rr_ptr and last_was_wr hold.
- Tag pipeline:
  - pred_lat stages, each holding {valid, id}. Stage 0 loads {tbl_rd_en, g}; stages shift every cycle regardless of en.
  - At the last stage, if valid and !flush[id]: rsp_valid[id]=1, rsp_hit=tbl_rd_hit, rsp_pred_pc=tbl_rd_data.
  - Otherwise rsp_valid=0, rsp_hit=0, rsp_pred_pc=0.
- Flush:
  - flush[i] clears the valid bit of every stage whose id==i, in the same cycle.
  - A response emerging in the same cycle as its flush is suppressed.
  - A pipe flushed in its grant cycle is not granted; arbitration moves to the next eligible pipe in that same cycle.
- Write/read hazard: no bypass. A read issued in the cycle after a write to the same PC sees the new data; the table itself handles write-before-read ordering.

Optional Feature:
Macro TARG_PRED_ARB_STATS_EN.
- Defined: adds two outputs, stat_rd_grant_cnt (32) and stat_rd_stall_cnt (32). Both are saturating and cleared by rst.
  - stat_rd_grant_cnt increments on every read grant.
  - stat_rd_stall_cnt increments on every cycle with en=1 in which some pipe is eligible but not granted, whether due to a write or to another pipe's grant.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=3'b111 held with all PCs distinct, pred_lat=1 → grants cycle pipe0, pipe1, pipe2, pipe0; each rsp_valid[g] fires exactly 1 cycle after its ack, carrying that pipe's tbl_rd_data.
- fb_valid and req_valid=3'b001 both held for 4 cycles → sequence is write, read0, write, read0; fb_ack and req_ack never high together.
- pred_lat=3: grant pipe1 at cycle t, assert flush[1] at t+2 → no rsp_valid at t+3; a pipe2 read granted at t+1 still responds at t+4.
- req_valid=3'b011 with flush=3'b001 in the same cycle, rr_ptr=0 → pipe1 granted; rr_ptr becomes 2.
- en=0 for 2 cycles with a read in flight → no new acks; the in-flight response is still delivered; rr_ptr is unchanged after en returns to 1.
- Assert rst while 2 reads are in flight (pred_lat=2) → no rsp_valid in the following cycles; rr_ptr=0, and the first grant after reset goes to pipe0.
